// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter and its bus watchdog.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '0;

  // Counter must reach TIMEOUT_CYCLES without wrapping; keep at least one bit.
  function automatic int unsigned wd_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Wishbone bus watchdog: raises a one-cycle ERR when a strobed access has gone
// unanswered for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables it.
module wb_bus_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic rty_i,
  output logic wd_err_o
);

  localparam int unsigned   CW      = wd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
  localparam logic          ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  always_comb begin
    waiting  = cyc_i & stb_i & ~(ack_i | err_i | rty_i);
    wd_err_o = ENABLED & waiting & (cnt_q == LIMIT);
    cnt_d    = '0;
    // Clearing on wd_err keeps the counter from ever exceeding LIMIT.
    if (ENABLED && waiting && !wd_err_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 classic arbiter: CYC-locked round-robin tenures,
// combinational request mux / response routing, and a bus watchdog.
module wb_arbiter2
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  wb_req_t    req0, req1, s_req;
  logic       own0, own1;
  logic       wd_err;

  assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                  adr: m0_adr_i, sel: m0_sel_i, dat: m0_dat_i};
  assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                  adr: m1_adr_i, sel: m1_sel_i, dat: m1_dat_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // On contention the master that did not own the previous tenure wins.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d      = GRANT0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = GRANT1;
          last_owner_d = 1'b1;
        end
      end
      GRANT0:  if (!m0_cyc_i) state_d = IDLE;
      GRANT1:  if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_req   = WB_REQ_IDLE;
    grant_o = 2'b00;
    case (state_q)
      GRANT0: begin
        s_req   = req0;
        grant_o = 2'b01;
      end
      GRANT1: begin
        s_req   = req1;
        grant_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign s_cyc_o = s_req.cyc;
  assign s_stb_o = s_req.stb;
  assign s_we_o  = s_req.we;
  assign s_adr_o = s_req.adr;
  assign s_sel_o = s_req.sel;
  assign s_dat_o = s_req.dat;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cyc_i    (s_cyc_o),
    .stb_i    (s_stb_o),
    .ack_i    (s_ack_i),
    .err_i    (s_err_i),
    .rty_i    (s_rty_i),
    .wd_err_o (wd_err)
  );

  // Responses reach only the current owner; anything seen while IDLE is dropped.
  assign own0      = (state_q == GRANT0);
  assign own1      = (state_q == GRANT1);
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = own0 & s_ack_i;
  assign m0_err_o  = own0 & (s_err_i | wd_err);
  assign m0_rty_o  = own0 & s_rty_i;
  assign m1_ack_o  = own1 & s_ack_i;
  assign m1_err_o  = own1 & (s_err_i | wd_err);
  assign m1_rty_o  = own1 & s_rty_i;
  assign timeout_o = wd_err;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus random traffic,
// compared every cycle against a tenure-level reference model.
module tb_wb_arbiter2;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err, s_rty;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  logic [31:0] m0_dat_z, m1_dat_z, s_adr_z, s_dat_z;
  logic        m0_ack_z, m0_err_z, m0_rty_z, m1_ack_z, m1_err_z, m1_rty_z;
  logic        s_cyc_z, s_stb_z, s_we_z, timeout_z;
  logic [3:0]  s_sel_z;
  logic [1:0]  grant_z;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, who had it last, how long the access waited.
  int owner = 0;   // 0 none, 1 master 0, 2 master 1
  int last  = 1;
  int wcnt  = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_arbiter2 #(.TIMEOUT_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_z), .m0_ack_o(m0_ack_z),
    .m0_err_o(m0_err_z), .m0_rty_o(m0_rty_z),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_z), .m1_ack_o(m1_ack_z),
    .m1_err_o(m1_err_z), .m1_rty_o(m1_rty_z),
    .s_cyc_o(s_cyc_z), .s_stb_o(s_stb_z), .s_we_o(s_we_z), .s_adr_o(s_adr_z),
    .s_dat_o(s_dat_z), .s_sel_o(s_sel_z), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(grant_z), .timeout_o(timeout_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 ns later and the
  // model advances at the rising edge.
  task automatic tick();
    logic        e_cyc, e_stb, e_we, waiting, wd;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    logic [1:0]  e_gnt;
    logic [2:0]  rsp;
    #1;
    if (rst) begin
      owner = 0; last = 1; wcnt = 0;
    end
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
    if (owner == 1) begin
      e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we; e_sel = m0_sel; e_adr = m0_adr; e_dat = m0_dat;
    end else if (owner == 2) begin
      e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we; e_sel = m1_sel; e_adr = m1_adr; e_dat = m1_dat;
    end
    e_gnt   = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    waiting = e_cyc & e_stb & !(s_ack | s_err | s_rty);
    wd      = waiting && (wcnt == TO);
    rsp     = {s_ack, s_err | wd, s_rty};
    chk("grant", {30'd0, grant_o}, {30'd0, e_gnt});
    chk("s_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, {e_cyc, e_stb, e_we, e_sel});
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_dat);
    chk("m0_rsp", {m0_ack_o, m0_err_o, m0_rty_o}, (owner == 1) ? rsp : 3'b000);
    chk("m1_rsp", {m1_ack_o, m1_err_o, m1_rty_o}, (owner == 2) ? rsp : 3'b000);
    chk("m_dat", m0_dat_o ^ m1_dat_o ^ s_dat, s_dat);
    chk("timeout", {31'd0, timeout_o}, {31'd0, wd});
    chk("z_rsp", {grant_z, m0_err_z, m1_err_z, timeout_z},
        {e_gnt, (owner == 1) & s_err, (owner == 2) & s_err, 1'b0});
    @(posedge clk);
    if (rst) begin
      owner = 0; last = 1; wcnt = 0;
    end else begin
      wcnt = (waiting && !wd) ? wcnt + 1 : 0;
      if (owner == 0) begin
        if (m0_cyc && (!m1_cyc || last == 1)) begin
          owner = 1; last = 0;
        end else if (m1_cyc) begin
          owner = 2; last = 1;
        end
      end else if (owner == 1 && !m0_cyc) begin
        owner = 0;
      end else if (owner == 2 && !m1_cyc) begin
        owner = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  initial begin
    bit quiet;
    bit seen;
    rst = 1'b1;
    m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_dat = '0;
    idle_all();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single master read with one wait state.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h1000_0000; m0_sel = 4'hF;
    tick();
    #1 chk("single_grant", {30'd0, grant_o}, 32'd1);
    tick();
    s_ack = 1; s_dat = 32'h1234_5678;
    #1 chk("single_ack", {m0_ack_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'b1000);
    chk("single_data", m0_dat_o, 32'h1234_5678);
    tick();
    idle_all();
    tick(); tick();

    // Contention from reset, locked tenure, then alternation.
    rst = 1; tick(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000_0010;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0100; m1_we = 1; m1_dat = 32'hA5A5_0001; m1_sel = 4'h3;
    tick();
    #1 chk("cont_first", {30'd0, grant_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      s_ack = i[0];
      #1 chk("locked", {30'd0, grant_o}, 32'd1);
      tick();
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("drop_scyc", {31'd0, s_cyc_o}, 32'd0);
    tick();
    #1 chk("dead_cycle", {30'd0, grant_o}, 32'd0);
    tick();
    #1 chk("cont_second", {30'd0, grant_o}, 32'd2);
    tick();
    m1_cyc = 0; m1_stb = 0; tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; tick();
    #1 chk("cont_alt", {30'd0, grant_o}, 32'd1);
    tick();
    idle_all(); tick(); tick();

    // Watchdog on an unmapped access from master 1.
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h2000_0000;
    tick();
    for (int k = 0; k <= TO; k++) begin
      #1 chk("wd_err", {m1_err_o, timeout_o, m0_err_o, m1_err_z, timeout_z},
             (k == TO) ? 32'b11000 : 32'b00000);
      tick();
    end
    idle_all(); tick(); tick();

    // Late ack one cycle before the timeout, then a fresh full wait.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000_0004;
    tick();
    for (int k = 0; k < TO; k++) begin
      s_ack = (k == TO - 1);
      #1 chk("late_ack", {m0_ack_o, m0_err_o, timeout_o}, (k == TO - 1) ? 32'b100 : 32'b000);
      tick();
    end
    s_ack = 0;
    for (int k = 0; k <= TO; k++) begin
      #1 chk("restart", {m0_err_o, timeout_o}, (k == TO) ? 32'b11 : 32'b00);
      tick();
    end
    // Disabled watchdog must stay silent on a very long wait.
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      #1 seen = seen | m0_err_z | timeout_z;
      tick();
    end
    chk("z_silent", {31'd0, seen}, 32'd0);
    idle_all(); tick(); tick();

    // Reset pulsed mid-tenure during a master 1 wait state.
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
    tick(); tick(); tick();
    s_ack = 1;
    #2 rst = 1;
    #1 chk("rst_async", {grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, timeout_o},
           32'd0);
    tick();
    rst = 0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    #1 chk("rst_cont", {30'd0, grant_o}, 32'd1);
    tick();
    idle_all(); tick();

    // Random traffic.
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) quiet = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if (m0_cyc) begin
        if ($urandom_range(0, quiet ? 31 : 7) == 0) begin
          m0_cyc = 0; m0_stb = 0;
        end else begin
          m0_stb = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m0_cyc = 1; m0_stb = 1;
      end
      if (m1_cyc) begin
        if ($urandom_range(0, quiet ? 31 : 7) == 0) begin
          m1_cyc = 0; m1_stb = 0;
        end else begin
          m1_stb = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m1_cyc = 1; m1_stb = 1;
      end
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
      s_dat = $urandom;
      s_ack = 0; s_err = 0; s_rty = 0;
      if (!quiet) begin
        case ($urandom_range(0, 5))
          0: s_ack = 1;
          1: s_err = 1;
          2: s_rty = 1;
          default: ;
        endcase
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
